// File: rtl/fetch_thread_scheduler.sv
// fetch_thread_scheduler
// Picks which of the four harts the instruction-fetch stage serves each cycle.
// Keeps one fetch PC per hart and a per-hart "waiting on refill" flag. Ready
// harts are served round-robin, starting after the last hart granted.
module fetch_thread_scheduler #(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter logic [31:0] THREAD_STRIDE = 32'h0000_0400
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic [3:0]  ThreadEnable,
   input  logic        Stall,
   input  logic        InstMiss,
   input  logic [1:0]  MissmhartID,
   input  logic [31:0] MissPC,
   input  logic        DoneRetrieving,
   input  logic [1:0]  RetrievingDoneFor,
   input  logic        Redirect,
   input  logic [1:0]  RedirectmhartID,
   input  logic [31:0] RedirectPC,
   output logic [1:0]  nextthread,
   output logic [31:0] ThreadAddress,
   output logic        InstSource,
   output logic [3:0]  WaitingMask
);

   // Per-hart architectural fetch state.
   logic [31:0] pc_r [4];
   logic [3:0]  waiting_r;
   logic [1:0]  lp_r;

   // Scheduling decision for the current cycle.
   logic [3:0]  miss_mask_s;
   logic [3:0]  elig_s;
   logic [1:0]  cand_s;
   logic [1:0]  grant_s;
   logic        found_s;
   logic        grant_fire_s;

   // Start PC of a given hart after reset.
   function automatic logic [31:0] start_pc(input int h);
      return RESET_PC + (32'(h) * THREAD_STRIDE);
   endfunction

   // Eligibility: enabled, not waiting on a refill, and not missing right now.
   always_comb begin
      miss_mask_s = InstMiss ? (4'b0001 << MissmhartID) : 4'b0000;
      elig_s      = ThreadEnable & ~waiting_r & ~miss_mask_s;
   end

   // Round-robin search: first eligible hart at or after lp+1, wrapping mod 4.
   always_comb begin
      found_s = 1'b0;
      grant_s = lp_r;
      cand_s  = lp_r;
      for (int i = 1; i <= 4; i++) begin
         cand_s = lp_r + i[1:0];
         if (!found_s && elig_s[cand_s]) begin
            found_s = 1'b1;
            grant_s = cand_s;
         end else begin
            found_s = found_s;
         end
      end
   end

   // A grant only takes effect when the fetch stage can accept it.
   assign grant_fire_s = found_s & ~Stall;

   // Grant outputs and last-grant pointer; held while stalled or when no hart is ready.
   always_ff @(posedge clk) begin
      if (Reset) begin
         nextthread    <= 2'd0;
         ThreadAddress <= 32'h0000_0000;
         InstSource    <= 1'b0;
         lp_r          <= 2'd3;
      end else if (Stall) begin
         nextthread    <= nextthread;
         ThreadAddress <= ThreadAddress;
         InstSource    <= InstSource;
         lp_r          <= lp_r;
      end else if (found_s) begin
         nextthread    <= grant_s;
         ThreadAddress <= pc_r[grant_s];
         InstSource    <= 1'b1;
         lp_r          <= grant_s;
      end else begin
         nextthread    <= nextthread;
         ThreadAddress <= ThreadAddress;
         InstSource    <= 1'b0;
         lp_r          <= lp_r;
      end
   end

   // Per-hart PC: redirect beats miss rewind, which beats the post-grant increment.
   always_ff @(posedge clk) begin
      for (int h = 0; h < 4; h++) begin
         if (Reset) begin
            pc_r[h] <= start_pc(h);
         end else if (Redirect && (RedirectmhartID == 2'(h))) begin
            pc_r[h] <= RedirectPC;
         end else if (InstMiss && (MissmhartID == 2'(h))) begin
            pc_r[h] <= MissPC;
         end else if (grant_fire_s && (grant_s == 2'(h))) begin
            pc_r[h] <= pc_r[h] + 32'd4;
         end else begin
            pc_r[h] <= pc_r[h];
         end
      end
   end

   // Per-hart refill wait flag: a new miss wins over a refill completing.
   always_ff @(posedge clk) begin
      for (int h = 0; h < 4; h++) begin
         if (Reset) begin
            waiting_r[h] <= 1'b0;
         end else if (InstMiss && (MissmhartID == 2'(h))) begin
            waiting_r[h] <= 1'b1;
         end else if (DoneRetrieving && (RetrievingDoneFor == 2'(h))) begin
            waiting_r[h] <= 1'b0;
         end else begin
            waiting_r[h] <= waiting_r[h];
         end
      end
   end

   assign WaitingMask = waiting_r;

endmodule

// File: tb/tb_fetch_thread_scheduler.sv
// Directed + short random bench for fetch_thread_scheduler. A behavioural
// reference model produces the expected outputs for each cycle; they are
// queued when the stimulus is applied and compared after the clock edge.
module tb_fetch_thread_scheduler;

   logic        clk = 1'b0;
   logic        Reset;
   logic [3:0]  ThreadEnable;
   logic        Stall;
   logic        InstMiss;
   logic [1:0]  MissmhartID;
   logic [31:0] MissPC;
   logic        DoneRetrieving;
   logic [1:0]  RetrievingDoneFor;
   logic        Redirect;
   logic [1:0]  RedirectmhartID;
   logic [31:0] RedirectPC;
   logic [1:0]  nextthread;
   logic [31:0] ThreadAddress;
   logic        InstSource;
   logic [3:0]  WaitingMask;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      logic [1:0]  nt;
      logic [31:0] addr;
      logic        src;
      logic [3:0]  wmask;
   } exp_t;

   exp_t exp_q[$];

   // Reference model state
   logic [31:0] m_pc [4];
   logic [3:0]  m_wait;
   int          m_lp;
   logic [1:0]  m_nt;
   logic [31:0] m_addr;
   logic        m_src;

   fetch_thread_scheduler dut (
      .clk               (clk),
      .Reset             (Reset),
      .ThreadEnable      (ThreadEnable),
      .Stall             (Stall),
      .InstMiss          (InstMiss),
      .MissmhartID       (MissmhartID),
      .MissPC            (MissPC),
      .DoneRetrieving    (DoneRetrieving),
      .RetrievingDoneFor (RetrievingDoneFor),
      .Redirect          (Redirect),
      .RedirectmhartID   (RedirectmhartID),
      .RedirectPC        (RedirectPC),
      .nextthread        (nextthread),
      .ThreadAddress     (ThreadAddress),
      .InstSource        (InstSource),
      .WaitingMask       (WaitingMask)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Advance the reference model by one clock edge using the current inputs.
   task automatic model_step(output exp_t e);
      logic [3:0]  elig;
      logic [31:0] new_pc [4];
      int          h;
      bit          found;
      if (Reset) begin
         for (int k = 0; k < 4; k++) m_pc[k] = 32'h0000_0400 * k;
         m_wait = 4'b0000;
         m_lp   = 3;
         m_nt   = 2'd0;
         m_addr = 32'h0;
         m_src  = 1'b0;
      end else begin
         elig = ThreadEnable & ~m_wait;
         if (InstMiss) elig[MissmhartID] = 1'b0;
         new_pc = m_pc;
         if (!Stall) begin
            found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
               h = (m_lp + k) % 4;
               if (!found && elig[h]) begin
                  found     = 1'b1;
                  m_nt      = 2'(h);
                  m_addr    = m_pc[h];
                  m_lp      = h;
                  new_pc[h] = m_pc[h] + 32'd4;
               end
            end
            m_src = found;
         end
         if (InstMiss) new_pc[MissmhartID] = MissPC;
         if (Redirect) new_pc[RedirectmhartID] = RedirectPC;
         m_pc = new_pc;
         if (DoneRetrieving) m_wait[RetrievingDoneFor] = 1'b0;
         if (InstMiss)       m_wait[MissmhartID] = 1'b1;
      end
      e.nt    = m_nt;
      e.addr  = m_addr;
      e.src   = m_src;
      e.wmask = m_wait;
   endtask

   task automatic compare_out();
      exp_t e;
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk("nextthread",    {30'd0, nextthread}, {30'd0, e.nt});
         chk("ThreadAddress", ThreadAddress, e.addr);
         chk("InstSource",    {31'd0, InstSource}, {31'd0, e.src});
         chk("WaitingMask",   {28'd0, WaitingMask}, {28'd0, e.wmask});
      end
   endtask

   // One clock: push expectation, let the edge happen, compare, clear one-shot events.
   task automatic tick();
      exp_t e;
      model_step(e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      compare_out();
      InstMiss       = 1'b0;
      DoneRetrieving = 1'b0;
      Redirect       = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      logic [1:0]  rr_nt   [5];
      logic [31:0] rr_addr [5];
      rr_nt   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      rr_addr = '{32'h0, 32'h400, 32'h800, 32'hC00, 32'h4};

      Reset = 1'b1; ThreadEnable = 4'h0; Stall = 1'b0;
      InstMiss = 1'b0; MissmhartID = 2'd0; MissPC = 32'h0;
      DoneRetrieving = 1'b0; RetrievingDoneFor = 2'd0;
      Redirect = 1'b0; RedirectmhartID = 2'd0; RedirectPC = 32'h0;

      // Reset state
      ticks(2);
      chk("reset_nextthread", {30'd0, nextthread}, 32'd0);
      chk("reset_addr", ThreadAddress, 32'h0);
      chk("reset_src", {31'd0, InstSource}, 32'd0);
      chk("reset_wmask", {28'd0, WaitingMask}, 32'd0);

      // Plain round-robin across all four harts
      Reset = 1'b0; ThreadEnable = 4'hF;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("rr_nt", {30'd0, nextthread}, {30'd0, rr_nt[k]});
         chk("rr_addr", ThreadAddress, rr_addr[k]);
         chk("rr_src", {31'd0, InstSource}, 32'd1);
      end

      // Miss on hart 1 while it is next in line; it must be skipped
      InstMiss = 1'b1; MissmhartID = 2'd1; MissPC = 32'h400;
      tick();
      chk("miss_skip_nt", {30'd0, nextthread}, 32'd2);
      chk("miss_wmask", {28'd0, WaitingMask}, 32'h2);
      ticks(3);
      DoneRetrieving = 1'b1; RetrievingDoneFor = 2'd1;
      ticks(4);

      // Both enabled harts blocked: grants stop, then resume after a refill
      ThreadEnable = 4'b0011;
      InstMiss = 1'b1; MissmhartID = 2'd0; MissPC = 32'h100;
      tick();
      InstMiss = 1'b1; MissmhartID = 2'd1; MissPC = 32'h500;
      tick();
      ticks(2);
      chk("allwait_src", {31'd0, InstSource}, 32'd0);
      DoneRetrieving = 1'b1; RetrievingDoneFor = 2'd0;
      tick();
      tick();
      chk("resume_nt", {30'd0, nextthread}, 32'd0);
      chk("resume_addr", ThreadAddress, 32'h100);
      DoneRetrieving = 1'b1; RetrievingDoneFor = 2'd1;
      ticks(3);

      // Redirect and miss on the same hart; miss and done on the same hart
      ThreadEnable = 4'hF;
      Redirect = 1'b1; RedirectmhartID = 2'd2; RedirectPC = 32'h2000;
      InstMiss = 1'b1; MissmhartID = 2'd2; MissPC = 32'h804;
      tick();
      InstMiss = 1'b1; MissmhartID = 2'd3; MissPC = 32'hC40;
      DoneRetrieving = 1'b1; RetrievingDoneFor = 2'd3;
      tick();
      chk("missdone_wmask", {28'd0, WaitingMask}, 32'hC);
      DoneRetrieving = 1'b1; RetrievingDoneFor = 2'd2;
      tick();
      DoneRetrieving = 1'b1; RetrievingDoneFor = 2'd3;
      ticks(6);

      // Stall for three cycles with a redirect landing during the stall
      Stall = 1'b1;
      tick();
      Redirect = 1'b1; RedirectmhartID = 2'd1; RedirectPC = 32'h3000;
      ticks(2);
      Stall = 1'b0;
      ticks(5);

      // Short random phase
      for (int k = 0; k < 60; k++) begin
         ThreadEnable      = 4'($urandom_range(0, 15));
         Stall             = ($urandom_range(0, 3) == 0);
         InstMiss          = ($urandom_range(0, 4) == 0);
         MissmhartID       = 2'($urandom_range(0, 3));
         MissPC            = {$urandom_range(0, 65535), 2'b00} & 32'h0003_FFFC;
         DoneRetrieving    = ($urandom_range(0, 2) == 0);
         RetrievingDoneFor = 2'($urandom_range(0, 3));
         Redirect          = ($urandom_range(0, 5) == 0);
         RedirectmhartID   = 2'($urandom_range(0, 3));
         RedirectPC        = {$urandom_range(0, 65535), 2'b00} | 32'h0010_0000;
         tick();
      end
      Stall = 1'b0; ThreadEnable = 4'hF;

      // Reset while hart 0 is waiting
      InstMiss = 1'b1; MissmhartID = 2'd0; MissPC = 32'h40;
      tick();
      Reset = 1'b1;
      tick();
      chk("rst_mid_wmask", {28'd0, WaitingMask}, 32'd0);
      Reset = 1'b0;
      tick();
      chk("rst_mid_nt", {30'd0, nextthread}, 32'd0);
      chk("rst_mid_addr", ThreadAddress, 32'h0);
      tick();
      chk("rst_mid_nt2", {30'd0, nextthread}, 32'd1);
      chk("rst_mid_addr2", ThreadAddress, 32'h400);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_thread_scheduler.md
# fetch_thread_scheduler

Selects the hardware thread (hart) the instruction-fetch stage serves each cycle in the 4-hart multithreaded RISC-V core. It holds one fetch PC per hart and tracks which harts are blocked on an instruction-cache refill. Each cycle it round-robins among the ready harts and drives the fetch stage's thread ID, fetch address and fetch-enable. It sits between the branch/jump resolution logic and the instruction-fetch stage, and consumes the instruction-cache miss and refill-done signals.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, start PC of hart 0.
- THREAD_STRIDE, 32'h0000_0400, start-PC spacing; hart h starts at RESET_PC + h*THREAD_STRIDE.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- ThreadEnable  in  4  bit h=1 means hart h may be scheduled.
- Stall  in  1  fetch stage cannot accept a new grant this cycle.
- InstMiss  in  1  the fetch for MissmhartID missed in the instruction cache.
- MissmhartID  in  2  hart that missed.
- MissPC  in  32  address of the missed fetch, to be replayed.
- DoneRetrieving  in  1  refill complete for RetrievingDoneFor.
- RetrievingDoneFor  in  2  hart whose refill completed.
- Redirect  in  1  branch/jump taken for RedirectmhartID.
- RedirectmhartID  in  2  hart being redirected.
- RedirectPC  in  32  new PC for that hart.
- nextthread  out  2  hart granted for fetch (registered).
- ThreadAddress  out  32  fetch PC of the granted hart (registered).
- InstSource  out  1  1 = grant valid this cycle (registered).
- WaitingMask  out  4  bit h=1 means hart h is blocked on a refill (registered).

## Operation
- State: PC[0..3] (32b), waiting[3:0], last-grant pointer lp (2b).
- Eligible mask E = ThreadEnable & ~waiting. When InstMiss=1, the bit for MissmhartID is also cleared in E, so a missing hart is never granted in its miss cycle.
- Grant, when Stall=0: pick the first hart in E starting at lp+1 (mod 4) and going upward.
  - On a grant to hart g: nextthread<=g, ThreadAddress<=PC[g], InstSource<=1, lp<=g, PC[g]<=PC[g]+4 (mod 2^32).
  - If E=0 and Stall=0: InstSource<=0. nextthread, ThreadAddress and lp hold.
- When Stall=1: nextthread, ThreadAddress, InstSource and lp hold, and no PC is incremented. Miss, refill-done and redirect updates still apply.
- Miss: waiting[MissmhartID]<=1 and PC[MissmhartID]<=MissPC.
- Refill done: waiting[RetrievingDoneFor]<=0. The hart becomes eligible in the following cycle.
- Redirect: PC[RedirectmhartID]<=RedirectPC. The waiting bit is unaffected.
- Same-hart priority per cycle, highest first: Reset > Redirect > Miss rewind > grant increment, for PC. For waiting, a miss set beats a refill-done clear.
- Events that target different harts in the same cycle all take effect.
- A hart whose ThreadEnable bit drops keeps its PC and waiting state; it is simply skipped.

## Timing
- Reset values:
  - nextthread=0, ThreadAddress=0, InstSource=0, WaitingMask=0.
  - lp=3, so the first grant goes to hart 0.
  - PC[h]=RESET_PC+h*THREAD_STRIDE.
- Reset asserted mid-operation discards all pending waiting/redirect state at that edge.
- Grant latency is 1 cycle: inputs sampled at edge n determine outputs valid after edge n.
- Miss-to-blocked takes effect at the same edge: the missing hart is excluded from the grant computed in that cycle.
- Refill-done to eligible: cleared at edge n, grantable at edge n+1.
- A redirect at edge n is visible in ThreadAddress at the hart's next grant, no earlier than edge n+1.
- With all 4 harts eligible and no stall, the grant sequence is 0,1,2,3,0,… and each hart is fetched every 4 cycles.
- With a single eligible hart, that hart is granted every cycle and PC advances by 4 per grant.

## Test plan
- Reset, then ThreadEnable=4'hF, no events: nextthread=0,1,2,3,0; ThreadAddress=0x0,0x400,0x800,0xC00,0x4; InstSource=1 throughout.
- Miss on hart 1 with MissPC=0x400 in cycle 2: hart 1 is skipped (sequence 2,3,0,2,…) and WaitingMask=4'b0010. DoneRetrieving for hart 1 four cycles later: hart 1 is granted again with ThreadAddress=0x400.
- All enabled harts missed (ThreadEnable=4'b0011, both waiting): InstSource=0 and outputs hold. A done for hart 0 restores InstSource=1, nextthread=0.
- Redirect hart 2 to 0x2000 together with a miss on hart 2 (MissPC=0x804): PC[2]=0x2000 (redirect wins) and waiting[2]=1. Miss and done for hart 3 in the same cycle: waiting[3]=1.
- Stall=1 for 3 cycles during round-robin: outputs, lp and PCs are frozen. A redirect applied during the stall appears at that hart's next grant after Stall drops.
- Reset asserted while hart 0 is waiting: WaitingMask=0, PCs return to their start values, the next grant is hart 0 at 0x0.
